adc_sample_buffer: RTL

- Downstream consumer of the ADC controller's 12-bit `data`/`ready` output.
- Captures each completed conversion into a synchronous FIFO.
- Drains the FIFO as a 2-byte-per-sample stream to the byte transmitter (UART/USB bridge) over a valid/ready handshake.
- Decouples bursty continuous-mode acquisition from the slower link and flags lost samples.

---
 rtl/adc_sample_buffer_pkg.sv | 22 ++
 rtl/adc_sample_buffer_fifo.sv | 85 ++++++++
 rtl/adc_sample_buffer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/adc_sample_buffer_pkg.sv
// Shared constants, FSM encoding and helpers for the ADC sample buffer.
package adc_sample_buffer_pkg;

   localparam int unsigned SAMPLE_W = 12;
   localparam int unsigned BYTE_W   = 8;
   localparam int unsigned DROP_W   = 8;

   localparam logic [3:0] HDR_DEFAULT = 4'hA;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      SEND_HI = 2'd2,
      SEND_LO = 2'd3
   } tx_state_e;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
   endfunction

endpackage

// File: rtl/adc_sample_buffer_fifo.sv
// Single-clock sample FIFO with registered read data and registered flags.
// A read of an empty FIFO alongside a write returns the incoming word.
module sample_fifo #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = 6,
   parameter int unsigned W     = 12
) (
   input  logic          clk_in,
   input  logic          rst,
   input  logic          clear,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic [W-1:0]  rd_data_q, rd_data_d;
   logic          do_wr, do_rd, mem_we;

   always_comb begin
      do_wr     = wr_en && !full_q;
      do_rd     = rd_en && (!empty_q || do_wr);
      mem_we    = do_wr && !clear;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      rd_data_d = rd_data_q;
      if (do_wr) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_rd) begin
         rd_ptr_d  = rd_ptr_q + AW'(1);
         rd_data_d = empty_q ? wr_data : mem_q[rd_ptr_q];
      end
      count_d = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      // Flush drops stored words; a read already issued still delivers its data.
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
      full_d  = (count_d == DEPTH_C);
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk_in) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         rd_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         full_q    <= full_d;
         empty_q   <= empty_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;
   assign count   = count_q;
   assign full    = full_q;
   assign empty   = empty_q;

endmodule

// File: rtl/adc_sample_buffer.sv
// Captures ADC conversions into a FIFO and streams each as a framed byte pair
// over a valid/ready link, counting samples lost to a full FIFO.
module adc_sample_buffer
   import adc_sample_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = 6,
   parameter logic [3:0]  HDR   = HDR_DEFAULT
) (
   input  logic                clk_in,
   input  logic                rst,
   input  logic                clear,
   input  logic [SAMPLE_W-1:0] adc_data,
   input  logic                adc_ready,
   output logic [BYTE_W-1:0]   tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic [AW:0]         fifo_count,
   output logic                empty,
   output logic                full,
   output logic                overflow,
   output logic [DROP_W-1:0]   drop_count
);

   logic                rdy_q, rdy_d;
   logic                cap_pend_q, cap_pend_d;
   logic                rise, cap_live, wr_en, drop, rd_en;
   tx_state_e           state_q, state_d;
   logic [BYTE_W-1:0]   sample_lo_q, sample_lo_d;
   logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
   logic                tx_valid_q, tx_valid_d;
   logic                overflow_q, overflow_d;
   logic [DROP_W-1:0]   drop_count_q, drop_count_d;
   logic [SAMPLE_W-1:0] rd_data;
   logic                fifo_full, fifo_empty;

   // Capture one cycle after the ready edge so adc_data has settled.
   always_comb begin
      rdy_d        = adc_ready;
      rise         = adc_ready & ~rdy_q;
      cap_pend_d   = rise;
      cap_live     = cap_pend_q & ~clear;
      wr_en        = cap_live & ~fifo_full;
      drop         = cap_live & fifo_full;
      overflow_d   = overflow_q | drop;
      drop_count_d = drop ? sat_inc(drop_count_q) : drop_count_q;
      if (clear) begin
         overflow_d   = 1'b0;
         drop_count_d = '0;
      end
   end

   sample_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (SAMPLE_W)
   ) u_fifo (
      .clk_in  (clk_in),
      .rst     (rst),
      .clear   (clear),
      .wr_en   (wr_en),
      .wr_data (adc_data),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Output FSM: fetch a sample, then present its high and low bytes.
   always_comb begin
      state_d     = state_q;
      sample_lo_d = sample_lo_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      rd_en       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty && !clear) begin
               rd_en   = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            sample_lo_d = rd_data[BYTE_W-1:0];
            tx_data_d   = {HDR, rd_data[SAMPLE_W-1:BYTE_W]};
            tx_valid_d  = 1'b1;
            state_d     = SEND_HI;
         end
         SEND_HI: begin
            if (tx_ready) begin
               tx_data_d = sample_lo_q;
               state_d   = SEND_LO;
            end
         end
         SEND_LO: begin
            if (tx_ready) begin
               tx_valid_d = 1'b0;
               // A same-cycle capture counts as available data.
               if ((!fifo_empty || wr_en) && !clear) begin
                  rd_en   = 1'b1;
                  state_d = LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         rdy_q        <= 1'b0;
         cap_pend_q   <= 1'b0;
         state_q      <= IDLE;
         sample_lo_q  <= '0;
         tx_data_q    <= '0;
         tx_valid_q   <= 1'b0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         rdy_q        <= rdy_d;
         cap_pend_q   <= cap_pend_d;
         state_q      <= state_d;
         sample_lo_q  <= sample_lo_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign tx_data    = tx_data_q;
   assign tx_valid   = tx_valid_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;
   assign full       = fifo_full;
   assign empty      = fifo_empty;

endmodule
